serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor: the control FSM state
// encoding and the default operand width.
package serial_subtractor_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
// One-bit combinational full subtractor used by the serial datapath.
// Ports:
//   in_a       minuend bit
//   in_b       subtrahend bit
//   in_borrow  borrow from the previous (less significant) bit
//   out_diff   difference bit
//   out_borrow borrow into the next (more significant) bit
module full_subtractor (
    input  logic in_a,
    input  logic in_b,
    input  logic in_borrow,
    output logic out_diff,
    output logic out_borrow
);

    assign out_diff   = in_a ^ in_b ^ in_borrow;
    // Borrow when b exceeds a, or when they are equal and a borrow ripples in.
    assign out_borrow = (~in_a & in_b) | (~(in_a ^ in_b) & in_borrow);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: accepts an operand pair with a valid/ready
// handshake, processes one bit per clock LSB first, and presents
// (in_a - in_b) mod 2^WIDTH together with the final borrow until consumed.
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds out_ovf, the signed
// two's-complement overflow flag of the same subtraction.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   block accepts operands (IDLE only)
//   in_a       minuend, unsigned
//   in_b       subtrahend, unsigned
//   out_valid  result available (DONE only)
//   out_ready  consumer takes result
//   out_diff   (in_a - in_b) mod 2^WIDTH
//   out_borrow 1 when in_a < in_b
//   out_ovf    signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             out_borrow,
    output logic             out_ovf
`else
    output logic             out_borrow
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic [WIDTH-1:0]  diff_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bor_q;
    logic              borrow_q;
    logic              ready_q;
    logic              valid_q;
    logic              d_s;
    logic              bor_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic              ovf_q;
`endif

    // Per-bit arithmetic always works on the current LSBs of the operand shifters.
    full_subtractor u_full_subtractor (
        .in_a       (a_q[0]),
        .in_b       (b_q[0]),
        .in_borrow  (bor_q),
        .out_diff   (d_s),
        .out_borrow (bor_s)
    );

    // Control FSM, serial datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= ZERO_W;
            b_q      <= ZERO_W;
            res_q    <= ZERO_W;
            diff_q   <= ZERO_W;
            cnt_q    <= {CNT_W{1'b0}};
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        bor_q   <= 1'b0;
                        cnt_q   <= {CNT_W{1'b0}};
                        ready_q <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= {1'b0, a_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    bor_q <= bor_s;
                    res_q <= {d_s, res_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_BIT) begin
                        // Last bit: publish the completed result alongside this bit.
                        diff_q   <= {d_s, res_q[WIDTH-1:1]};
                        borrow_q <= bor_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // Operand LSBs are now the original sign bits; d_s is the result sign.
                        ovf_q    <= (a_q[0] ^ b_q[0]) & (d_s ^ a_q[0]);
`endif
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = valid_q;
    assign out_diff   = diff_q;
    assign out_borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic         out_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         out_ovf;
`endif

    exp_t sb[$];
    int   n_vec;
    int   n_miss;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf)
`else
        .out_borrow (out_borrow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  full;
        full     = {1'b0, a} - {1'b0, b};
        e.diff   = full[W-1:0];
        e.borrow = (a < b);
        e.ovf    = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    endtask

    // Accept a/b, check latency, optionally stall the consumer for hold cycles, consume.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   lat;
        bit   got;
        wait_ready(tag);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(model(a, b));
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        lat = 0; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (out_valid === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        check({tag, "_diff"}, 64'(out_diff), 64'(e.diff));
        check({tag, "_borrow"}, 64'(out_borrow), 64'(e.borrow));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check({tag, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = ~a; in_b = a ^ 8'h5A;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_hold_diff"}, 64'(out_diff), 64'(e.diff));
            check({tag, "_hold_borrow"}, 64'(out_borrow), 64'(e.borrow));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_consumed_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_consumed_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_diff_kept"}, 64'(out_diff), 64'(e.diff));
    endtask

    initial begin
        int stray;
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 8'h00; in_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_diff", 64'(out_diff), 64'd0);
        check("rst_out_borrow", 64'(out_borrow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("5m3", 8'h05, 8'h03, 0);
        run_op("3m5", 8'h03, 8'h05, 0);
        run_op("0m0", 8'h00, 8'h00, 0);
        run_op("FFmFF", 8'hFF, 8'hFF, 0);
        run_op("C3m3C_hold", 8'hC3, 8'h3C, 5);
        // The operands offered during the stall must not have been taken.
        run_op("after_hold", 8'h21, 8'h42, 0);

        // Abandon an operation with reset in the middle of the shift.
        wait_ready("rst_op");
        in_a = 8'hAA; in_b = 8'h55; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(model(8'hAA, 8'h55));
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_diff", 64'(out_diff), 64'd0);
        check("midrst_out_borrow", 64'(out_borrow), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray++;
        end
        check("midrst_no_result", 64'(stray), 64'd0);
        check("midrst_diff_zero", 64'(out_diff), 64'd0);
        run_op("10m01", 8'h10, 8'h01, 0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        run_op("ovf_80m01", 8'h80, 8'h01, 0);
        run_op("ovf_7Fm01", 8'h7F, 8'h01, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
